pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the P7 MIPS core, replacing the per-stage hand-written D/E, E/M and M/W registers. It carries instruction, PC, a data payload, writeback destination and Tnew. It supports stall (hold), flush (bubble that keeps PC and delay-slot flag for EPC), exception/interrupt clear, and first-exception-wins ExcCode merging. A saturating bubble counter is provided for debug.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_stage_reg_exc_merge.sv | 32 +++
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the P7 pipeline registers: boot/handler
// addresses, ExcCode encodings and the fixed-width part of a stage record.
package pipe_pkg;

    localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDRESS = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_NONE    = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // Payload and Tnew are parameter-sized, so they live outside this record.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  a3;
        logic        rfwr;
        logic [4:0]  exc;
        logic        bd;
    } stage_hdr_t;

    function automatic logic [4:0] first_exc(input logic [4:0] older,
                                             input logic [4:0] younger);
        return (older != EXC_NONE) ? older : younger;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_exc_merge.sv
// ExcCode merge: the exception already carried by the instruction wins over
// one detected in this stage; an excepting instruction may lose its writeback.
module exc_merge
    import pipe_pkg::*;
#(
    parameter bit KILL_ON_EXC = 1'b1
) (
    input  logic [4:0] in_exc,
    input  logic [4:0] new_exc,
    input  logic       in_rfwr,
    input  logic [4:0] in_a3,
    output logic [4:0] exc_o,
    output logic       rfwr_o,
    output logic [4:0] a3_o
);

    logic kill;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        exc_o  = first_exc(in_exc, new_exc);
        kill   = KILL_ON_EXC && (exc_o != EXC_NONE);
        rfwr_o = in_rfwr;
        a3_o   = in_a3;
        if (kill) begin
            rfwr_o = 1'b0;
            a3_o   = 5'd0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register (D/E, E/M, M/W) with stall, flush bubbles that
// keep EPC/BD, exception clear, ExcCode merging and a saturating bubble count.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TNEW_W      = 2,
    parameter int unsigned TNEW_DEC    = 1,
    parameter bit          KILL_ON_EXC = 1'b1,
    parameter logic [31:0] RESET_PC    = INITIAL_ADDRESS,
    parameter logic [31:0] HANDLER_PC  = HANDLER_ADDRESS,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_a3,
    input  logic              in_rfwr,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [4:0]        in_exc,
    input  logic [4:0]        new_exc,
    input  logic              in_bd,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_a3,
    output logic              out_rfwr,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [4:0]        out_exc,
    output logic              out_bd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [TNEW_W-1:0] TNEW_DEC_W = TNEW_W'(TNEW_DEC);

    localparam stage_hdr_t RESET_HDR = '{
        valid: 1'b0, instr: 32'd0, pc: RESET_PC, a3: 5'd0,
        rfwr: 1'b0, exc: 5'd0, bd: 1'b0
    };

    stage_hdr_t        hdr_q, hdr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0] merged_exc;
    logic       merged_rfwr;
    logic [4:0] merged_a3;

    exc_merge #(
        .KILL_ON_EXC (KILL_ON_EXC)
    ) u_exc_merge (
        .in_exc  (in_exc),
        .new_exc (new_exc),
        .in_rfwr (in_rfwr),
        .in_a3   (in_a3),
        .exc_o   (merged_exc),
        .rfwr_o  (merged_rfwr),
        .a3_o    (merged_a3)
    );

    always_comb begin
        hdr_d  = hdr_q;
        data_d = data_q;
        tnew_d = tnew_q;
        cnt_d  = cnt_q;

        if (req) begin
            hdr_d    = '0;
            hdr_d.pc = HANDLER_PC;
            data_d   = '0;
            tnew_d   = '0;
        end else if (flush) begin
            // A bubble keeps PC and BD so EPC/BD stay correct if it is the
            // oldest slot when an interrupt is taken.
            hdr_d    = '0;
            hdr_d.pc = in_pc;
            hdr_d.bd = in_bd;
            data_d   = '0;
            tnew_d   = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!stall) begin
            hdr_d.valid = in_valid;
            hdr_d.instr = in_instr;
            hdr_d.pc    = in_pc;
            hdr_d.bd    = in_bd;
            data_d      = in_data;
            if (in_valid) begin
                hdr_d.exc  = merged_exc;
                hdr_d.rfwr = merged_rfwr;
                hdr_d.a3   = merged_a3;
                tnew_d     = (in_tnew >= TNEW_DEC_W) ? in_tnew - TNEW_DEC_W : '0;
            end else begin
                hdr_d.exc  = 5'd0;
                hdr_d.rfwr = 1'b0;
                hdr_d.a3   = 5'd0;
                tnew_d     = '0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of the others; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q  <= RESET_HDR;
            data_q <= '0;
            tnew_q <= '0;
            cnt_q  <= '0;
        end else begin
            hdr_q  <= hdr_d;
            data_q <= data_d;
            tnew_q <= tnew_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid  = hdr_q.valid;
    assign out_instr  = hdr_q.instr;
    assign out_pc     = hdr_q.pc;
    assign out_data   = data_q;
    assign out_a3     = hdr_q.a3;
    assign out_rfwr   = hdr_q.rfwr;
    assign out_tnew   = tnew_q;
    assign out_exc    = hdr_q.exc;
    assign out_bd     = hdr_q.bd;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: an E/M-style instance (kill on, Tnew-1, 2-bit
// counter) and a pass-through instance (kill off, Tnew kept) share stimulus.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [63:0] data;
        logic [4:0]  a3;
        logic        rfwr;
        logic [1:0]  tnew;
        logic [4:0]  exc;
        logic        bd;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, req, flush, stall;
    logic        in_valid, in_rfwr, in_bd;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_data;
    logic [4:0]  in_a3, in_exc, new_exc;
    logic [1:0]  in_tnew;

    logic        a_valid, a_rfwr, a_bd, b_valid, b_rfwr, b_bd;
    logic [31:0] a_instr, a_pc, b_instr, b_pc;
    logic [63:0] a_data, b_data;
    logic [4:0]  a_a3, a_exc, b_a3, b_exc;
    logic [1:0]  a_tnew, b_tnew, a_cnt;
    logic [15:0] b_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t m_a, m_b;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(64), .TNEW_W(2), .TNEW_DEC(1), .KILL_ON_EXC(1'b1),
        .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180), .CNT_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .in_a3(in_a3), .in_rfwr(in_rfwr), .in_tnew(in_tnew), .in_exc(in_exc),
        .new_exc(new_exc), .in_bd(in_bd),
        .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc), .out_data(a_data),
        .out_a3(a_a3), .out_rfwr(a_rfwr), .out_tnew(a_tnew), .out_exc(a_exc),
        .out_bd(a_bd), .bubble_cnt(a_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(64), .TNEW_W(2), .TNEW_DEC(0), .KILL_ON_EXC(1'b0),
        .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180), .CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .req(req), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
        .in_a3(in_a3), .in_rfwr(in_rfwr), .in_tnew(in_tnew), .in_exc(in_exc),
        .new_exc(new_exc), .in_bd(in_bd),
        .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc), .out_data(b_data),
        .out_a3(b_a3), .out_rfwr(b_rfwr), .out_tnew(b_tnew), .out_exc(b_exc),
        .out_bd(b_bd), .bubble_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Next-state reference built directly from the priority list of the block.
    function automatic exp_t model_next(input exp_t cur, input int dec,
                                        input bit kill, input logic [15:0] cmax);
        exp_t n;
        n = cur;
        if (reset) begin
            n    = '0;
            n.pc = 32'h0000_3000;
        end else if (req) begin
            n     = '0;
            n.pc  = 32'h0000_4180;
            n.cnt = cur.cnt;
        end else if (flush) begin
            n     = '0;
            n.pc  = in_pc;
            n.bd  = in_bd;
            n.cnt = (cur.cnt == cmax) ? cur.cnt : cur.cnt + 16'd1;
        end else if (!stall) begin
            n.valid = in_valid;
            n.instr = in_instr;
            n.pc    = in_pc;
            n.data  = in_data;
            n.bd    = in_bd;
            n.exc   = (in_exc != 5'd0) ? in_exc : new_exc;
            n.tnew  = (int'(in_tnew) >= dec) ? 2'(int'(in_tnew) - dec) : 2'd0;
            n.rfwr  = in_rfwr;
            n.a3    = in_a3;
            if (kill && n.exc != 5'd0) begin
                n.rfwr = 1'b0;
                n.a3   = 5'd0;
            end
            if (!in_valid) begin
                n.rfwr = 1'b0;
                n.a3   = 5'd0;
                n.tnew = 2'd0;
                n.exc  = 5'd0;
            end
        end
        return n;
    endfunction

    task automatic compare_outputs();
        exp_t ea, eb;
        if (q_a.size() == 0 || q_b.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("a.valid", 64'(a_valid), 64'(ea.valid));
        check("a.instr", 64'(a_instr), 64'(ea.instr));
        check("a.pc",    64'(a_pc),    64'(ea.pc));
        check("a.data",  a_data,       ea.data);
        check("a.a3",    64'(a_a3),    64'(ea.a3));
        check("a.rfwr",  64'(a_rfwr),  64'(ea.rfwr));
        check("a.tnew",  64'(a_tnew),  64'(ea.tnew));
        check("a.exc",   64'(a_exc),   64'(ea.exc));
        check("a.bd",    64'(a_bd),    64'(ea.bd));
        check("a.cnt",   64'(a_cnt),   64'(ea.cnt));
        check("b.valid", 64'(b_valid), 64'(eb.valid));
        check("b.instr", 64'(b_instr), 64'(eb.instr));
        check("b.pc",    64'(b_pc),    64'(eb.pc));
        check("b.data",  b_data,       eb.data);
        check("b.a3",    64'(b_a3),    64'(eb.a3));
        check("b.rfwr",  64'(b_rfwr),  64'(eb.rfwr));
        check("b.tnew",  64'(b_tnew),  64'(eb.tnew));
        check("b.exc",   64'(b_exc),   64'(eb.exc));
        check("b.bd",    64'(b_bd),    64'(eb.bd));
        check("b.cnt",   64'(b_cnt),   64'(eb.cnt));
    endtask

    // Drive is already set up by the caller; predict, clock, compare.
    task automatic step();
        m_a = model_next(m_a, 1, 1'b1, 16'd3);
        m_b = model_next(m_b, 0, 1'b0, 16'hffff);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic drive_load(input logic [31:0] pc, input logic [1:0] tnew,
                              input logic [4:0] a3, input logic rfwr,
                              input logic [4:0] ie, input logic [4:0] ne);
        reset = 1'b0; req = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = 32'h2000_0000 | pc;
        in_data  = {pc, ~pc};
        in_tnew  = tnew;
        in_a3    = a3;
        in_rfwr  = rfwr;
        in_exc   = ie;
        new_exc  = ne;
        in_bd    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] codes [6];
        int         sat_seq [5];
        codes   = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        sat_seq = '{1, 2, 3, 3, 3};

        reset = 1'b1; req = 1'b0; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; in_data = '0; in_a3 = '0;
        in_rfwr = 1'b0; in_tnew = '0; in_exc = '0; new_exc = '0; in_bd = 1'b0;
        m_a = '0; m_b = '0;

        // Reset state
        step();
        check("rst_pc",   64'(a_pc), 64'h3000);
        check("rst_rfwr", 64'(a_rfwr), 64'd0);
        check("rst_tnew", 64'(a_tnew), 64'd0);
        check("rst_cnt",  64'(a_cnt), 64'd0);

        // E/M load: Tnew decremented by one, fields copied
        drive_load(32'h3004, 2'd2, 5'd5, 1'b1, 5'd0, 5'd0);
        step();
        check("ld_tnew",   64'(a_tnew), 64'd1);
        check("ld_a3",     64'(a_a3), 64'd5);
        check("ld_pc",     64'(a_pc), 64'h3004);
        check("ld_tnew_b", 64'(b_tnew), 64'd2);

        // Tnew=0 stays 0
        drive_load(32'h3008, 2'd0, 5'd6, 1'b1, 5'd0, 5'd0);
        step();
        check("tnew_floor", 64'(a_tnew), 64'd0);

        // Load then hold for three cycles while inputs change
        drive_load(32'h3008, 2'd3, 5'd7, 1'b1, 5'd0, 5'd0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'hdead_0000 + 32'(i);
            in_tnew = 2'd0;
            step();
            check("stall_pc",   64'(a_pc), 64'h3008);
            check("stall_tnew", 64'(a_tnew), 64'd2);
        end

        // Flush with stall high: flush wins, bubble keeps PC/BD
        flush = 1'b1; in_pc = 32'h300c; in_bd = 1'b1;
        step();
        check("fl_valid", 64'(a_valid), 64'd0);
        check("fl_instr", 64'(a_instr), 64'd0);
        check("fl_rfwr",  64'(a_rfwr), 64'd0);
        check("fl_pc",    64'(a_pc), 64'h300c);
        check("fl_bd",    64'(a_bd), 64'd1);
        check("fl_cnt",   64'(a_cnt), 64'd1);

        // Exception merge: new exception kills writeback when enabled
        drive_load(32'h3010, 2'd1, 5'd8, 1'b1, 5'd0, 5'd12);
        step();
        check("exc_new",    64'(a_exc), 64'd12);
        check("exc_kill_w", 64'(a_rfwr), 64'd0);
        check("exc_kill_a", 64'(a_a3), 64'd0);
        check("nokill_w",   64'(b_rfwr), 64'd1);
        check("nokill_a",   64'(b_a3), 64'd8);

        // Earlier exception wins
        drive_load(32'h3014, 2'd1, 5'd9, 1'b1, 5'd4, 5'd12);
        step();
        check("exc_first", 64'(a_exc), 64'd4);

        // Invalid slot: pc/bd copied, writeback info cleared
        drive_load(32'h3018, 2'd3, 5'd10, 1'b1, 5'd0, 5'd0);
        in_valid = 1'b0; in_bd = 1'b1;
        step();
        check("inv_pc",   64'(a_pc), 64'h3018);
        check("inv_rfwr", 64'(b_rfwr), 64'd0);
        check("inv_tnew", 64'(b_tnew), 64'd0);

        // req beats flush and stall; counter unchanged
        drive_load(32'h301c, 2'd2, 5'd11, 1'b1, 5'd0, 5'd0);
        req = 1'b1; flush = 1'b1; stall = 1'b1;
        step();
        check("req_pc",    64'(a_pc), 64'h4180);
        check("req_valid", 64'(a_valid), 64'd0);
        check("req_tnew",  64'(a_tnew), 64'd0);
        check("req_cnt",   64'(a_cnt), 64'd1);

        // Reset mid-stall
        drive_load(32'h3020, 2'd2, 5'd3, 1'b1, 5'd0, 5'd0);
        step();
        stall = 1'b1; reset = 1'b1;
        step();
        check("rst_stall_pc", 64'(a_pc), 64'h3000);

        // Saturating bubble counter on the 2-bit instance
        reset = 1'b0; stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_pc = 32'h3100 + 32'(4 * i);
            step();
            check("sat_cnt", 64'(a_cnt), 64'(sat_seq[i]));
        end

        // Random mix of controls and payloads
        for (int i = 0; i < 80; i++) begin
            reset    = ($urandom_range(0, 24) == 0);
            req      = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 4) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            in_instr = $urandom;
            in_pc    = $urandom;
            in_data  = {$urandom, $urandom};
            in_a3    = 5'($urandom_range(0, 31));
            in_rfwr  = 1'($urandom_range(0, 1));
            in_tnew  = 2'($urandom_range(0, 3));
            in_exc   = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 5)] : 5'd0;
            new_exc  = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 5)] : 5'd0;
            in_bd    = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
